byte_serial_subtractor: RTL and testbench
=========================================

BYTE_SERIAL_SUBTRACTOR -- requirements
Module: byte_serial_subtractor

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand and result width.
REQ-002 The block SHALL have parameter SLICE_W, default 8, bits processed per cycle; DATA_W SHALL be an integer multiple of SLICE_W.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  operand pair valid.
REQ-006 o_ready  output  1  block can accept operands.
REQ-007 i_a  input  DATA_W  minuend.
REQ-008 i_b  input  DATA_W  subtrahend.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  downstream accepts result.
REQ-011 o_diff  output  DATA_W  i_a - i_b modulo 2^DATA_W.
REQ-012 o_borrow  output  1  unsigned borrow, i_a < i_b.
REQ-013 o_ovf  output  1  signed two's-complement overflow.

Function
REQ-014 The FSM SHALL have the states IDLE, CALC and DONE. NUM_SLICES = DATA_W/SLICE_W.
REQ-015 o_ready SHALL be 1 only in IDLE. o_valid SHALL be 1 only in DONE. Both outputs SHALL be registered.
REQ-016 Accept: on an edge with state IDLE and i_valid=1, the block SHALL capture i_a and i_b, clear the slice index to 0, set the internal carry to 1 and go to CALC.
REQ-017 Inputs outside IDLE SHALL be ignored, and a captured operand SHALL NOT change until the next accept.
REQ-018 CALC processes one slice k per edge: diff[k] = a[k] + ~b[k] + carry. The carry-out SHALL be registered as the carry for slice k+1, and k SHALL increment.
REQ-019 After slice NUM_SLICES-1 the FSM SHALL go to DONE. o_valid SHALL rise exactly NUM_SLICES edges after the accept edge (4 with defaults).
REQ-020 On entry to DONE the flags SHALL be set as follows: o_borrow = NOT(final carry-out); o_ovf = (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]).
REQ-021 In DONE with i_ready=0, o_valid, o_diff, o_borrow and o_ovf SHALL hold stable.
REQ-022 In DONE with i_ready=1, the FSM SHALL return to IDLE on that edge. o_diff and the flags SHALL keep their last values until the next DONE entry.
REQ-023 Minimum initiation interval SHALL be NUM_SLICES+2 cycles. There is no accept in the same cycle as a result handoff.
REQ-024 Wrap-around SHALL be modular, with no saturation; b=0 SHALL give diff=a, borrow=0, ovf=0.

Reset
REQ-025 With i_rst_n=0 at an edge, the block SHALL enter IDLE with o_ready=1, o_valid=0, o_diff=0, o_borrow=0, o_ovf=0, carry=1 and slice index=0.
REQ-026 Reset in CALC or DONE SHALL discard the in-flight operation, and no result SHALL be presented for it.
REQ-027 The first accept SHALL be possible on the first edge with i_rst_n=1.

Structure
REQ-028 A shared package SHALL hold the DATA_W and SLICE_W defaults, NUM_SLICES and the state enumeration (IDLE, CALC, DONE).
REQ-029 The per-slice arithmetic SHALL be one combinational sub-module, sub_slice_8. It SHALL take a slice, b slice and carry-in, and produce the difference slice and carry-out.
REQ-030 The FSM, slice index counter, operand/result registers and flag logic SHALL reside in the top module.

Verification
REQ-031 The bench SHALL cover these directed scenarios, plus a random-operand check against a reference model:
- a=0x00000005, b=0x00000003 -> diff=0x00000002, borrow=0, ovf=0; o_valid rises 4 edges after accept.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1, ovf=0.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrow=0, ovf=1.
- a=0x01000000, b=0x00000001 (borrow ripples across 3 slices) -> diff=0x00FFFFFF, borrow=0, ovf=0.
- Hold i_ready=0 for 10 cycles in DONE while driving i_valid=1 with new operands -> outputs stable, o_ready=0, new operands ignored; release i_ready -> IDLE next cycle.
- Assert i_rst_n=0 for one edge after 2 CALC cycles -> next cycle o_valid=0, o_ready=1, o_diff=0; a new operation then completes correctly.

Source files
------------

// File: rtl/byte_serial_subtractor_pkg.sv
// Shared defaults, state encoding and flag helper for the byte-serial subtractor.
package byte_serial_subtractor_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int SLICE_W_DEF    = 8;
  localparam int NUM_SLICES_DEF = DATA_W_DEF / SLICE_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Signed overflow of a - b: operand signs differ and the result sign left the minuend's.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/byte_serial_subtractor_sub_slice.sv
// One combinational slice of a - b computed as a + ~b + carry-in.
module sub_slice_8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_diff,
  output logic         o_cout
);

  logic [W:0] sum_s;

  assign sum_s  = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, i_cin};
  assign o_diff = sum_s[W-1:0];
  assign o_cout = sum_s[W];

endmodule

// File: rtl/byte_serial_subtractor.sv
// Multi-cycle subtractor: one SLICE_W slice per clock, result and flags held until handed off.
module byte_serial_subtractor
  import byte_serial_subtractor_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_diff,
  output logic              o_borrow,
  output logic              o_ovf
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   diff_q, diff_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;

  logic [SLICE_W-1:0]  slice_a_s, slice_b_s, slice_d_s;
  logic                slice_cout_s;

  assign slice_a_s = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign slice_b_s = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  sub_slice_8 #(.W(SLICE_W)) u_slice (
    .i_a    (slice_a_s),
    .i_b    (slice_b_s),
    .i_cin  (carry_q),
    .o_diff (slice_d_s),
    .o_cout (slice_cout_s)
  );

  // Next-state, datapath and flag computation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          idx_d   = '0;
          carry_d = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d[int'(idx_q)*SLICE_W +: SLICE_W] = slice_d_s;
        carry_d = slice_cout_s;
        if (idx_q == LAST_IDX) begin
          // Result and flags only become visible here, so o_diff never shows partial sums.
          diff_d   = acc_d;
          borrow_d = ~slice_cout_s;
          ovf_d    = sub_ovf(a_q[DATA_W-1], b_q[DATA_W-1], acc_d[DATA_W-1]);
          idx_d    = '0;
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_byte_serial_subtractor.sv
// Self-checking bench: directed cases plus random operands against an arithmetic reference.
module tb_byte_serial_subtractor;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_ready;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid, o_borrow, o_ovf;
  logic [31:0] o_diff;

  int n_cmp = 0;
  int n_bad = 0;

  byte_serial_subtractor dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_diff   (o_diff),
    .o_borrow (o_borrow),
    .o_ovf    (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed overflow from exact wide signed arithmetic.
  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d > 64'sd2147483647) || (d < -64'sd2147483648);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    check("ready_before_accept", o_ready, 1);
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    tick();
    i_valid = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
    check("ready_after_accept", o_ready, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    int          n;
    logic [31:0] ed;
    ed = a - b;
    accept(a, b);
    wait_done(n);
    check("latency", n, 4);
    check("diff", o_diff, ed);
    check("borrow", o_borrow, (a < b));
    check("ovf", o_ovf, ref_ovf(a, b));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", o_valid, 1);
      check("hold_diff", o_diff, ed);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("handoff_ready", o_ready, 1);
    check("handoff_valid", o_valid, 0);
    check("handoff_diff_kept", o_diff, ed);
  endtask

  initial begin
    int          n;
    int          seen;
    logic [31:0] ra, rb, sd;
    logic        sbor, sovf;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_a     = '0;
    i_b     = '0;
    tick();
    tick();
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_diff", o_diff, 0);
    check("rst_borrow", o_borrow, 0);
    check("rst_ovf", o_ovf, 0);

    // First accept lands on the first edge with reset released.
    i_rst_n = 1'b1;
    do_op(32'h0000_0005, 32'h0000_0003, 0);
    do_op(32'h0000_0000, 32'h0000_0001, 1);
    do_op(32'h8000_0000, 32'h0000_0001, 0);
    do_op(32'h0100_0000, 32'h0000_0001, 2);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(32'hDEAD_BEEF, 32'h0000_0000, 0);
    do_op(32'h1234_5678, 32'h1234_5678, 0);

    // Stall in DONE while new operands are offered; they must be ignored.
    accept(32'h1234_5678, 32'h2111_1111);
    wait_done(n);
    check("stall_latency", n, 4);
    sd   = 32'h1234_5678 - 32'h2111_1111;
    sbor = 1'b1;
    sovf = ref_ovf(32'h1234_5678, 32'h2111_1111);
    for (int i = 0; i < 10; i++) begin
      i_valid = 1'b1;
      i_a     = $urandom;
      i_b     = $urandom;
      tick();
      check("stall_valid", o_valid, 1);
      check("stall_ready", o_ready, 0);
      check("stall_diff", o_diff, sd);
      check("stall_flags", {o_borrow, o_ovf}, {sbor, sovf});
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("stall_release_ready", o_ready, 1);
    check("stall_release_valid", o_valid, 0);
    check("stall_release_diff", o_diff, sd);

    // Reset mid-calculation discards the operation.
    accept(32'hCAFE_0001, 32'h0000_0FFF);
    tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_diff", o_diff, 0);
    check("midrst_flags", {o_borrow, o_ovf}, 2'b00);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    do_op(32'h0000_0100, 32'h0000_0200, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 3) rb = 32'h0;
      if (i % 10 == 7) rb = ra;
      if (i % 10 == 9) rb = {ra[31:8], 8'hFF} + 32'h1;
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
